data_cache: RTL
===============

# data_cache

Direct-mapped, write-back, write-allocate data cache between the processor's load/store stage and the line-based `memory` block. Serves 32-bit word loads and stores from a local line array on a hit in the same cycle. On a miss it stalls the pipeline, writes back the victim line if dirty, fetches the 128-bit line, and replays the access. It is the sole master of the memory's read and write ports and honours that block's hold-address-until-done handshake.

## Interface
- `LINES`, 16, number of cache lines; must be a power of 2.
- `INDEX_BITS`, 4, log2(`LINES`).
- `clk` input 1, the only clock; all state updates on posedge.
- `rst` input 1, synchronous, active-high reset.
- `req_valid` input 1, processor access request.
- `req_we` input 1, 1 = store word, 0 = load word.
- `req_addr` input 32, byte address; bits [1:0] ignored.
- `req_wdata` input 32, store data.
- `req_ready` output 1, access completes this cycle (hit); 0 = stall.
- `rsp_rdata` output 32, load data; valid when `req_valid && !req_we && req_ready`.
- `rAddr` output 32, memory read line address; bits [3:0] always 0.
- `rData` input 128, memory read line.
- `rValid` input 1, memory read data valid for the current `rAddr`.
- `wAddr` output 32, memory write line address; bits [3:0] always 0.
- `wData` output 128, memory write line.
- `WE` output 1, memory write enable.
- `wDone` input 1, memory write completed for the current `wAddr`.

## Operation
- Address split: offset [3:2] selects the word in the line; index [INDEX_BITS+3:4]; tag [31:INDEX_BITS+4].
- Per line: valid bit, dirty bit, tag, 128-bit data.
- State machine: IDLE, WRITEBACK, FILL.
- IDLE: combinational lookup of `req_addr`. Hit means valid and tag equal.
  - Hit: `req_ready`=1. A load drives `rsp_rdata` with the selected word. A store writes the word at posedge and sets dirty.
  - Miss with victim valid and dirty: go to WRITEBACK.
  - Any other miss: go to FILL.
  - `req_valid`=0: stay in IDLE, no array change.
- WRITEBACK: register `wAddr` = {victim tag, index, 4'b0}, `wData` = victim line, `WE`=1 on entry. Hold all three stable until `wDone`=1. On that edge, clear victim dirty, drop `WE`, and go to FILL.
- FILL: register `rAddr` = {req tag, index, 4'b0} on entry and hold it. The `rValid` edge is ignored in the first FILL cycle. Any later `rValid`=1 edge installs `rData` with valid=1, dirty=0, new tag, and returns to IDLE. The replayed request then hits.
- `req_ready`=0 in WRITEBACK and FILL. The processor holds `req_*` stable while `req_ready`=0.
- When not in WRITEBACK, `WE`=0. `wAddr`/`wData` keep their last value. `rAddr` keeps the last fill address outside FILL.

## Timing
- Reset values: all valid and dirty bits 0, state IDLE, `WE`=0, `rAddr`=0, `wAddr`=0, `wData`=0, `req_ready`=0 during `rst`, `rsp_rdata`=0 during `rst`.
- Hit latency: 0 cycles. Data is combinational in the request cycle; a store is visible to a load the next cycle.
- Miss latency is set by the memory handshake. The cache never counts cycles; it waits on `wDone`/`rValid` only.
  - With memory delays 5/7 and changed addresses: `wDone` arrives in WRITEBACK cycle 7 and `rValid` in FILL cycle 9.
  - Clean miss is about 10 cycles to hit; dirty miss is about 17.
- `WE` is low for at least 1 cycle between consecutive write-backs, so the memory write counter restarts even for the same `wAddr`.
- `rAddr` changes only on FILL entry.
- Reset mid-WRITEBACK or mid-FILL: return to IDLE next cycle, `WE`=0, all lines invalid. No partial install.
- `rValid` or `wDone` seen in IDLE: ignored.

## Test plan
- Cold load at 0x100: stall, `rAddr`=0x100, then `rsp_rdata` = memory word at 0x100 with `req_ready`=1. An immediate reload of 0x104 hits in 1 cycle.
- Store 0xDEADBEEF to 0x208, then load 0x208 → hit returning 0xDEADBEEF; `WE` never asserts.
- Conflict: store to 0x000, then load 0x100 (LINES=16 → same index). `WE`=1 with `wAddr`=0x000 and `wData` word0=store data until `wDone`. Then FILL of 0x100. Reload of 0x000 returns the stored value read back from memory.
- Clean conflict miss: load 0x000, then load 0x100 → no `WE` pulse, direct FILL.
- Two back-to-back dirty evictions of the same line address → `WE` drops ≥1 cycle between them, and both writes land in memory.
- Assert `rst` during FILL: next cycle `req_ready`=0 and `WE`=0. After release, the first access misses.

Source files
------------

// File: rtl/data_cache_if.sv
// Processor-side request/response and memory-side line port of the data cache.
interface data_cache_if;
  // processor load/store stage
  logic         req_valid;
  logic         req_we;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         req_ready;
  logic [31:0]  rsp_rdata;
  // line memory
  logic [31:0]  rAddr;
  logic [127:0] rData;
  logic         rValid;
  logic [31:0]  wAddr;
  logic [127:0] wData;
  logic         WE;
  logic         wDone;

  // cache side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rData, rValid, wDone,
    output req_ready, rsp_rdata, rAddr, wAddr, wData, WE
  );

  // processor + memory side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rData, rValid, wDone,
    input  req_ready, rsp_rdata, rAddr, wAddr, wData, WE
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache. Hits complete in the
// request cycle; misses write back a dirty victim, fetch the line, and let the
// held request replay as a hit.
module data_cache #(
  parameter int LINES      = 16,
  parameter int INDEX_BITS = 4
) (
  input logic         clk,
  input logic         rst,
  data_cache_if.slave bus
);
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;

  state_e                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [LINES-1:0]      dirty_q, dirty_d;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [127:0]          data_q [LINES];
  logic [31:0]           rAddr_q, rAddr_d;
  logic [31:0]           wAddr_q, wAddr_d;
  logic [127:0]          wData_q, wData_d;
  logic                  WE_q, WE_d;
  // first FILL cycle: rValid may still refer to the previous rAddr
  logic                  fill_first_q, fill_first_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [1:0]            off;
  logic                  hit;
  logic                  ready;
  logic                  line_we;
  logic [127:0]          line_wdata;
  logic [TAG_BITS-1:0]   line_wtag;
  logic                  unused_addr;

  assign idx         = bus.req_addr[INDEX_BITS+3:4];
  assign tag         = bus.req_addr[31:INDEX_BITS+4];
  assign off         = bus.req_addr[3:2];
  assign hit         = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_addr = ^bus.req_addr[1:0];

  assign bus.req_ready = ready && !rst;
  assign bus.rsp_rdata = rst ? 32'h0 : data_q[idx][{off, 5'b0} +: 32];
  assign bus.rAddr     = rAddr_q;
  assign bus.wAddr     = wAddr_q;
  assign bus.wData     = wData_q;
  assign bus.WE        = WE_q;

  // Lookup, miss sequencing and line-array update selection
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    rAddr_d      = rAddr_q;
    wAddr_d      = wAddr_q;
    wData_d      = wData_q;
    WE_d         = WE_q;
    fill_first_d = 1'b0;
    ready        = 1'b0;
    line_we      = 1'b0;
    line_wdata   = data_q[idx];
    line_wtag    = tag_q[idx];
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (hit) begin
            ready = 1'b1;
            if (bus.req_we) begin
              line_we                        = 1'b1;
              line_wdata[{off, 5'b0} +: 32]  = bus.req_wdata;
              dirty_d[idx]                   = 1'b1;
            end
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_d = WRITEBACK;
            wAddr_d = {tag_q[idx], idx, 4'b0};
            wData_d = data_q[idx];
            WE_d    = 1'b1;
          end else begin
            state_d      = FILL;
            rAddr_d      = {tag, idx, 4'b0};
            fill_first_d = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        if (bus.wDone) begin
          dirty_d[idx] = 1'b0;
          WE_d         = 1'b0;
          state_d      = FILL;
          rAddr_d      = {tag, idx, 4'b0};
          fill_first_d = 1'b1;
        end
      end
      FILL: begin
        if (!fill_first_q && bus.rValid) begin
          line_we      = 1'b1;
          line_wdata   = bus.rData;
          line_wtag    = tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and memory-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      rAddr_q      <= '0;
      wAddr_q      <= '0;
      wData_q      <= '0;
      WE_q         <= 1'b0;
      fill_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      rAddr_q      <= rAddr_d;
      wAddr_q      <= wAddr_d;
      wData_q      <= wData_d;
      WE_q         <= WE_d;
      fill_first_q <= fill_first_d;
    end
  end

  // Line data/tag array; contents are meaningless while the valid bit is clear
  always_ff @(posedge clk) begin
    if (line_we && !rst) begin
      data_q[idx] <= line_wdata;
      tag_q[idx]  <= line_wtag;
    end
  end
endmodule
